bip_control: RTL and testbench
==============================

# bip_control

Sequencing control unit for the BIP accumulator processor. It fetches 16-bit instructions from a synchronous-read program memory and decodes the 5-bit opcode. It then drives the datapath's mux selects, ALU operation, accumulator write, operand and the data-memory read/write strobes, one instruction at a time, until a HLT. It sits between the program memory, the data memory and the datapath, and is the only block that advances the PC.

## Interface
- PC_W, 11, program-counter and operand width
- INSTR_W, 16, instruction width; opcode = [15:11], operand = [10:0]
- CNT_W, 16, retired-instruction counter width
- i_clk  in  1  single clock; all state changes on rising edge
- i_reset  in  1  asynchronous, active-low reset; forces IDLE and all outputs to reset values
- i_start  in  1  level; sampled only in IDLE or HALT; starts execution at PC 0
- i_instr  in  16  program-memory read data, valid the cycle after o_instr_rd
- o_pc  out  PC_W  program-memory address
- o_instr_rd  out  1  program-memory read enable
- o_operando  out  PC_W  latched operand to the datapath (also the data address)
- o_valid  out  1  datapath enable
- o_sel_a  out  2  00 memory, 01 sign-extended operand, 10 ALU result
- o_sel_b  out  1  0 memory, 1 operand
- o_operacion  out  1  0 add, 1 subtract
- o_write_acc  out  1  accumulator write enable
- o_data_rd / o_data_wr  out  1 each  data-memory read / write strobe
- o_busy  out  1  high in FETCH, DECODE, MEM and EXEC
- o_done  out  1  one-cycle pulse on entry to HALT
- o_retired  out  CNT_W  instructions retired since last start, saturating

## Operation
- Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111.
- Any other opcode is a NOP: no strobes, PC increments, and it counts as retired.
- States and transitions:
  - IDLE -> FETCH on i_start; this clears the PC and o_retired.
  - FETCH -> DECODE.
  - DECODE -> MEM if the opcode is LD, ADD or SUB.
  - DECODE -> HALT if the opcode is HLT.
  - DECODE -> EXEC otherwise.
  - MEM -> EXEC.
  - EXEC -> FETCH.
  - HALT -> FETCH on i_start; this also clears the PC and o_retired.
- FETCH: o_instr_rd=1, o_pc=PC.
- DECODE: latch i_instr into the instruction register; o_operando updates from the operand field.
- MEM: o_data_rd=1 and o_valid=1, so read data arrives during EXEC.
- EXEC: o_valid=1 and the decoded control word is driven for exactly one cycle.
  - LD: sel_a=00, write_acc=1.
  - LDI: sel_a=01, write_acc=1.
  - ADD: sel_b=0, op=0, sel_a=10, write_acc=1.
  - ADDI: sel_b=1, op=0, sel_a=10, write_acc=1.
  - SUB and SUBI: same as ADD and ADDI with op=1.
  - STO: o_data_wr=1, write_acc=0.
- Leaving EXEC: PC <= PC+1 and o_retired increments.
- PC is PC_W bits and wraps 2047 -> 0 silently.
- o_retired saturates at all-ones.
- HLT is not counted as retired; PC holds at the HLT address.
- i_start outside IDLE/HALT is ignored.

## Timing
- Reset values: all strobes 0, o_valid 0, o_sel_a 00, o_sel_b 0, o_operacion 0, o_pc 0, o_operando 0, o_busy 0, o_done 0, o_retired 0. State is IDLE.
- All outputs are registered or decoded from registered state only, with no combinational path from i_instr.
- Latency per instruction:
  - 3 cycles (FETCH, DECODE, EXEC) for LDI, ADDI, SUBI, STO and NOP.
  - 4 cycles for LD, ADD and SUB.
- HLT takes 2 cycles from FETCH to HALT.
- The datapath accumulator captures on the falling edge inside EXEC. Control must be stable for the whole EXEC cycle.
- Reset asserted mid-instruction aborts it. Any write strobe drops asynchronously and nothing is retired.
- Program-memory read latency is exactly 1 cycle; data-memory read latency is exactly 1 cycle.

## Structure
- Shared include bip_defs.vh holds:
  - the opcode localparams;
  - the mux-select encodings (MEMORIA/OPERANDO/RESULTADO), which the datapath also uses;
  - the state encodings.
- Sub-module bip_decoder: purely combinational, maps opcode to {needs_mem, is_halt, sel_a, sel_b, operacion, write_acc, data_wr}. bip_control registers its outputs.

## Test plan
- Reset during EXEC of STO -> o_data_wr falls immediately, state IDLE, o_retired 0, o_pc 0.
- Program LDI 5; ADDI 3; STO 7; HLT -> one o_data_wr pulse with o_operando 7; o_done after 11 cycles from FETCH; o_retired 3; o_pc 3.
- Program LD 2; SUB 4; HLT -> o_data_rd pulses at MEM with o_operando 2 and then 4; sel_a 00 then 10, operacion 1; 4+4+2 cycles.
- Opcode 11111 at PC 0, then HLT -> no strobes; o_retired 1; halts at PC 1.
- i_start held high for the whole run -> no restart until HALT; restart from HALT clears o_retired and refetches PC 0.
- PC wrap: 2048 NOPs (opcode 11111), then HLT fetched at address 0 on the second pass -> o_pc wraps 2047 -> 0; o_retired 2048.

Source files
------------

// File: rtl/bip_control_pkg.sv
// Shared definitions for the BIP control unit: opcodes, datapath mux encodings,
// FSM state encoding and the decoded control-word layout.
package bip_control_pkg;

   localparam int unsigned OpW = 5;

   localparam logic [OpW-1:0] OpHlt  = 5'b00000;
   localparam logic [OpW-1:0] OpSto  = 5'b00001;
   localparam logic [OpW-1:0] OpLd   = 5'b00010;
   localparam logic [OpW-1:0] OpLdi  = 5'b00011;
   localparam logic [OpW-1:0] OpAdd  = 5'b00100;
   localparam logic [OpW-1:0] OpAddi = 5'b00101;
   localparam logic [OpW-1:0] OpSub  = 5'b00110;
   localparam logic [OpW-1:0] OpSubi = 5'b00111;

   // Accumulator source select, shared with the datapath
   localparam logic [1:0] SelAMemoria   = 2'b00;
   localparam logic [1:0] SelAOperando  = 2'b01;
   localparam logic [1:0] SelAResultado = 2'b10;

   localparam logic SelBMemoria  = 1'b0;
   localparam logic SelBOperando = 1'b1;

   localparam logic AluAdd = 1'b0;
   localparam logic AluSub = 1'b1;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StMem    = 3'd3,
      StExec   = 3'd4,
      StHalt   = 3'd5
   } state_e;

   // Fields driven to the datapath during EXEC
   typedef struct packed {
      logic [1:0] sel_a;
      logic       sel_b;
      logic       operacion;
      logic       write_acc;
      logic       data_wr;
   } exec_ctrl_t;

   typedef struct packed {
      logic       needs_mem;
      logic       is_halt;
      exec_ctrl_t exec;
   } dec_ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder for the BIP control unit. Unlisted opcodes
// decode to an all-zero control word, i.e. a NOP.
module bip_decoder
   import bip_control_pkg::*;
(
   input  logic [OpW-1:0] opcode_i,
   output dec_ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (opcode_i)
         OpHlt: ctrl_o.is_halt = 1'b1;
         OpSto: ctrl_o.exec.data_wr = 1'b1;
         OpLd: begin
            ctrl_o.needs_mem      = 1'b1;
            ctrl_o.exec.sel_a     = SelAMemoria;
            ctrl_o.exec.write_acc = 1'b1;
         end
         OpLdi: begin
            ctrl_o.exec.sel_a     = SelAOperando;
            ctrl_o.exec.write_acc = 1'b1;
         end
         OpAdd, OpSub: begin
            ctrl_o.needs_mem      = 1'b1;
            ctrl_o.exec.sel_a     = SelAResultado;
            ctrl_o.exec.sel_b     = SelBMemoria;
            ctrl_o.exec.operacion = (opcode_i == OpSub) ? AluSub : AluAdd;
            ctrl_o.exec.write_acc = 1'b1;
         end
         OpAddi, OpSubi: begin
            ctrl_o.exec.sel_a     = SelAResultado;
            ctrl_o.exec.sel_b     = SelBOperando;
            ctrl_o.exec.operacion = (opcode_i == OpSubi) ? AluSub : AluAdd;
            ctrl_o.exec.write_acc = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bip_control.sv
// BIP sequencing control unit: fetch/decode/mem/exec FSM that owns the PC and
// drives the datapath control word, one instruction at a time until HLT.
module bip_control
   import bip_control_pkg::*;
#(
   parameter int unsigned PC_W    = 11,
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [INSTR_W-1:0] i_instr,
   output logic [PC_W-1:0]    o_pc,
   output logic               o_instr_rd,
   output logic [PC_W-1:0]    o_operando,
   output logic               o_valid,
   output logic [1:0]         o_sel_a,
   output logic               o_sel_b,
   output logic               o_operacion,
   output logic               o_write_acc,
   output logic               o_data_rd,
   output logic               o_data_wr,
   output logic               o_busy,
   output logic               o_done,
   output logic [CNT_W-1:0]   o_retired
);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  operand_q, operand_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   exec_ctrl_t       ctrl_q, ctrl_d;
   logic             done_q, done_d;
   dec_ctrl_t        dec_ctrl;
   logic             in_exec;

   // Decoding i_instr only feeds state registers, never an output directly
   bip_decoder u_decoder (
      .opcode_i (i_instr[INSTR_W-1 -: OpW]),
      .ctrl_o   (dec_ctrl)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      operand_d = operand_q;
      retired_d = retired_q;
      ctrl_d    = ctrl_q;
      case (state_q)
         StIdle, StHalt: begin
            if (i_start) begin
               state_d   = StFetch;
               pc_d      = '0;
               retired_d = '0;
            end
         end
         StFetch: state_d = StDecode;
         StDecode: begin
            operand_d = i_instr[PC_W-1:0];
            ctrl_d    = dec_ctrl.exec;
            if (dec_ctrl.is_halt) begin
               state_d = StHalt;
            end else if (dec_ctrl.needs_mem) begin
               state_d = StMem;
            end else begin
               state_d = StExec;
            end
         end
         StMem: state_d = StExec;
         StExec: begin
            state_d = StFetch;
            pc_d    = pc_q + PC_W'(1);
            if (retired_q != {CNT_W{1'b1}}) begin
               retired_d = retired_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      done_d = (state_d == StHalt) && (state_q != StHalt);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= StIdle;
         pc_q      <= '0;
         operand_q <= '0;
         retired_q <= '0;
         ctrl_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         operand_q <= operand_d;
         retired_q <= retired_d;
         ctrl_q    <= ctrl_d;
         done_q    <= done_d;
      end
   end

   // Strobes decode from registered state so an async reset drops them at once
   assign in_exec     = (state_q == StExec);
   assign o_pc        = pc_q;
   assign o_operando  = operand_q;
   assign o_retired   = retired_q;
   assign o_done      = done_q;
   assign o_instr_rd  = (state_q == StFetch);
   assign o_data_rd   = (state_q == StMem);
   assign o_valid     = (state_q == StMem) || in_exec;
   assign o_busy      = (state_q == StFetch) || (state_q == StDecode) ||
                        (state_q == StMem) || in_exec;
   assign o_sel_a     = in_exec ? ctrl_q.sel_a : SelAMemoria;
   assign o_sel_b     = in_exec && ctrl_q.sel_b;
   assign o_operacion = in_exec && ctrl_q.operacion;
   assign o_write_acc = in_exec && ctrl_q.write_acc;
   assign o_data_wr   = in_exec && ctrl_q.data_wr;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: a reference walk of each program pushes
// the expected MEM/EXEC control words, a negedge monitor pops and compares them.
module tb_bip_control;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [15:0] i_instr;
   logic [10:0] o_pc;
   logic        o_instr_rd;
   logic [10:0] o_operando;
   logic        o_valid;
   logic [1:0]  o_sel_a;
   logic        o_sel_b;
   logic        o_operacion;
   logic        o_write_acc;
   logic        o_data_rd;
   logic        o_data_wr;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_retired;

   int n_total = 0;
   int n_bad   = 0;

   logic [15:0] prog [2048];
   logic [31:0] sb [$];

   bip_control dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_start     (i_start),
      .i_instr     (i_instr),
      .o_pc        (o_pc),
      .o_instr_rd  (o_instr_rd),
      .o_operando  (o_operando),
      .o_valid     (o_valid),
      .o_sel_a     (o_sel_a),
      .o_sel_b     (o_sel_b),
      .o_operacion (o_operacion),
      .o_write_acc (o_write_acc),
      .o_data_rd   (o_data_rd),
      .o_data_wr   (o_data_wr),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_retired   (o_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program memory with one-cycle synchronous read
   always @(posedge clk) begin
      if (o_instr_rd) i_instr <= prog[o_pc];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ev(input logic mem, input logic [10:0] pc,
                                      input logic [10:0] opd, input logic [5:0] cw);
      return {3'b000, mem, pc, opd, cw};
   endfunction

   // {needs_mem, sel_a[1:0], sel_b, operacion, write_acc, data_wr}
   function automatic logic [6:0] ref_dec(input logic [4:0] op);
      case (op)
         5'b00001: return 7'b0_00_0_0_0_1;
         5'b00010: return 7'b1_00_0_0_1_0;
         5'b00011: return 7'b0_01_0_0_1_0;
         5'b00100: return 7'b1_10_0_0_1_0;
         5'b00101: return 7'b0_10_1_0_1_0;
         5'b00110: return 7'b1_10_0_1_1_0;
         5'b00111: return 7'b0_10_1_1_1_0;
         default:  return 7'b0_00_0_0_0_0;
      endcase
   endfunction

   task automatic model_prog(output int cyc, output int ret, output int pc_end);
      logic [10:0] pc;
      logic [15:0] ins;
      logic [6:0]  d;
      pc  = '0;
      cyc = 0;
      ret = 0;
      for (int s = 0; s < 4096; s++) begin
         ins = prog[pc];
         if (ins[15:11] == 5'b00000) begin
            cyc += 2;
            break;
         end
         d = ref_dec(ins[15:11]);
         if (d[6]) begin
            sb.push_back(ev(1'b1, pc, ins[10:0], 6'b0));
            cyc += 4;
         end else begin
            cyc += 3;
         end
         sb.push_back(ev(1'b0, pc, ins[10:0], d[5:0]));
         pc = pc + 11'd1;
         ret++;
      end
      pc_end = int'(pc);
   endtask

   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            check("ctrl_word", ev(o_data_rd, o_pc, o_operando,
                  {o_sel_a, o_sel_b, o_operacion, o_write_acc, o_data_wr}), sb.pop_front());
         end
      end
   end

   task automatic clear_prog();
      for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
   endtask

   task automatic kick(input bit hold);
      @(negedge clk);
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) i_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int cnt0, input int exp_cyc,
                            input int exp_ret, input int exp_pc);
      int cnt;
      bit seen;
      cnt  = cnt0;
      seen = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (o_done) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_cycles"}, cnt, exp_cyc);
      check({tag, "_retired"}, 32'(o_retired), exp_ret);
      check({tag, "_pc"}, 32'(o_pc), exp_pc);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_sb_drained"}, sb.size(), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
   endtask

   initial begin
      int cyc, ret, pce;
      rst_n   = 1'b0;
      i_start = 1'b0;
      i_instr = '0;
      clear_prog();
      #3;
      check("reset_outputs", {7'b0, o_pc, o_operando, o_instr_rd, o_valid, o_sel_a,
            o_sel_b, o_operacion, o_write_acc, o_data_rd, o_data_wr, o_busy},
            32'd0);
      check("reset_done_retired", {15'b0, o_done, o_retired}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // LDI 5; ADDI 3; STO 7; HLT
      clear_prog();
      prog[0] = {5'b00011, 11'd5};
      prog[1] = {5'b00101, 11'd3};
      prog[2] = {5'b00001, 11'd7};
      prog[3] = {5'b00000, 11'd0};
      model_prog(cyc, ret, pce);
      kick(1'b0);
      wait_done("ldi_addi_sto", 0, cyc, ret, pce);
      check("ldi_addi_sto_cyc_ref", cyc, 32'd11);

      // LD 2; SUB 4; HLT
      clear_prog();
      prog[0] = {5'b00010, 11'd2};
      prog[1] = {5'b00110, 11'd4};
      model_prog(cyc, ret, pce);
      kick(1'b0);
      wait_done("ld_sub", 0, 10, 2, 2);

      // Unknown opcode behaves as a counted NOP
      clear_prog();
      prog[0] = {5'b11111, 11'h12};
      model_prog(cyc, ret, pce);
      kick(1'b0);
      wait_done("nop", 0, 5, 1, 1);

      // i_start held high: ignored while busy, restarts from HALT
      clear_prog();
      prog[0] = {5'b00011, 11'd5};
      model_prog(cyc, ret, pce);
      kick(1'b1);
      wait_done("hold", 0, 5, 1, 1);
      check("restart_fetch", 32'(o_instr_rd), 32'd1);
      check("restart_pc", 32'(o_pc), 32'd0);
      check("restart_retired", 32'(o_retired), 32'd0);
      model_prog(cyc, ret, pce);
      i_start = 1'b0;
      wait_done("hold2", 0, 5, 1, 1);

      // PC wrap: 2048 NOPs, then HLT seen at address 0 on the second pass
      for (int i = 0; i < 2048; i++) begin
         prog[i] = {5'b11111, 11'(i)};
         sb.push_back(ev(1'b0, 11'(i), 11'(i), 6'b0));
      end
      kick(1'b0);
      @(posedge clk);
      @(negedge clk);
      prog[0] = {5'b00000, 11'd0};
      wait_done("wrap", 1, 2048 * 3 + 2, 2048, 0);

      // Reset during EXEC of STO aborts it
      clear_prog();
      prog[0] = {5'b00011, 11'd1};
      prog[1] = {5'b00001, 11'd9};
      model_prog(cyc, ret, pce);
      kick(1'b0);
      begin
         bit seen_wr;
         seen_wr = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_data_wr) begin
               seen_wr = 1'b1;
               break;
            end
         end
         check("sto_wr_seen", 32'(seen_wr), 32'd1);
      end
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_data_wr", 32'(o_data_wr), 32'd0);
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_retired", 32'(o_retired), 32'd0);
      check("abort_pc", 32'(o_pc), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_idle", {30'b0, o_busy, o_instr_rd}, 32'd0);
      check("abort_sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
